// File: rtl/cpu_controller_if.sv
// Opcode/flag inputs and datapath strobes between the sequencer and the CPU datapath.
// The resume input exists only when CPU_CTRL_RESUME_EN is defined.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
`ifdef CPU_CTRL_RESUME_EN
  logic       resume;
`endif
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       data_e;
  logic       wr;
  logic       halt;

  modport master (
`ifdef CPU_CTRL_RESUME_EN
    input  resume,
`endif
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
  );

  modport slave (
`ifdef CPU_CTRL_RESUME_EN
    output resume,
`endif
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt
  );
endinterface

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer for the 8-bit RISC CPU; strobes decode combinationally from phase.
// Optional CPU_CTRL_RESUME_EN: a resume pulse while halted restarts at phase 5 of the HLT instruction.
module cpu_controller (
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.master bus
);
  localparam int NPHASE = 8;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic [2:0] phase_reg;
  logic       halted_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else if (halted_reg) begin
`ifdef CPU_CTRL_RESUME_EN
      if (bus.resume) begin
        halted_reg <= 1'b0;
        phase_reg  <= OP_FETCH;
      end
`endif
    end else if (phase_reg == OP_ADDR && bus.opcode == OP_HLT) begin
      halted_reg <= 1'b1;
    end else if (phase_reg == 3'(NPHASE - 1)) begin
      phase_reg <= INST_ADDR;
    end else begin
      phase_reg <= phase_reg + 3'd1;
    end
  end

  // Equality decodes (no default masking) so an X opcode shows up as X on dependent strobes.
  logic is_hlt, is_skz, is_sto, is_jmp, aluop;
  assign is_hlt = (bus.opcode == OP_HLT);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign aluop  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.data_e = 1'b0;
    bus.wr     = 1'b0;
    bus.halt   = 1'b0;
    if (halted_reg) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
        end
        OP_FETCH: bus.rd = aluop;
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = is_jmp;
          bus.inc_pc = is_jmp;
          bus.data_e = is_sto;
          bus.wr     = is_sto;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboarded bench for cpu_controller: stimulus queues hand-computed strobe vectors,
// a negedge monitor pops and compares {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt}.
module tb_cpu_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] common[4];
  logic [8:0] act;

  localparam logic [8:0] V_RST  = 9'b100000000;
  localparam logic [8:0] V_ZERO = 9'b000000000;
  localparam logic [8:0] V_HLTD = 9'b000000001;

  assign act = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.data_e, bus.wr, bus.halt};

  // Monitor: compares the oldest expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      checks++;
      if (act !== cur.v) begin
        errors++;
        $display("FAIL %s got %b want %b", cur.tag, act, cur.v);
      end else begin
        $display("%0t %s strobes %b", $time, cur.tag, act);
      end
    end
    if (rst === 1'b0) begin
      checks++;
      if ((bus.wr & bus.ld_ac) !== 1'b0) begin
        errors++;
        $display("FAIL wr_ld_ac_excl got wr=%b ld_ac=%b want not both", bus.wr, bus.ld_ac);
      end
    end
  end

  task automatic push(input logic [8:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs phases first..last of one instruction; opcode is scrambled while the IR loads.
  task automatic run_instr(input logic [2:0] op, input logic z,
                           input logic [8:0] p5, input logic [8:0] p6, input logic [8:0] p7,
                           input int first, input int last, input string nm);
    logic [8:0] v;
    for (int p = first; p <= last; p++) begin
      bus.opcode = (p < 4) ? 3'($urandom_range(0, 7)) : op;
      bus.zero   = (p == 6) ? z : 1'($urandom_range(0, 1));
      case (p)
        0, 1, 2, 3: v = common[p];
        4:          v = (op == 3'd0) ? 9'b000100001 : 9'b000100000;
        5:          v = p5;
        6:          v = p6;
        default:    v = p7;
      endcase
      push(v, $sformatf("%s_p%0d", nm, p));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    common[0] = 9'b100000000;
    common[1] = 9'b110000000;
    common[2] = 9'b111000000;
    common[3] = 9'b111000000;
    rst        = 1'b1;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
`ifdef CPU_CTRL_RESUME_EN
    bus.resume = 1'b0;
`endif
    step();
    push(V_RST, "rst_hold");
    step();
    rst = 1'b0;

    run_instr(3'd2, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000, 0, 7, "add");
    run_instr(3'd5, 1'b1, 9'b010000000, 9'b010000000, 9'b010001000, 0, 7, "lda");
    run_instr(3'd6, 1'b0, V_ZERO, 9'b000000100, 9'b000000110, 0, 7, "sto");
    run_instr(3'd1, 1'b1, V_ZERO, 9'b000100000, V_ZERO, 0, 7, "skz_z1");
    run_instr(3'd1, 1'b0, V_ZERO, V_ZERO, V_ZERO, 0, 7, "skz_z0");
    run_instr(3'd7, 1'b1, V_ZERO, 9'b000010000, 9'b000110000, 0, 7, "jmp");

    // Reset asserted in the middle of phase 5.
    run_instr(3'd4, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000, 0, 4, "xor");
    rst = 1'b1;
    push(V_RST, "rst_mid_p5");
    step();
    push(V_RST, "rst_held");
    step();
    rst = 1'b0;
    push(V_RST, "rst_rel_p0");
    step();
    run_instr(3'd3, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000, 1, 7, "and");

    // Halt: phase 4 shows halt, then frozen with only halt asserted.
    run_instr(3'd0, 1'b0, V_ZERO, V_ZERO, V_ZERO, 0, 4, "hlt");
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 3'($urandom_range(0, 7));
      bus.zero   = 1'($urandom_range(0, 1));
      push(V_HLTD, $sformatf("halted_%0d", i));
      step();
    end

`ifdef CPU_CTRL_RESUME_EN
    bus.opcode = 3'd0;
    bus.resume = 1'b1;
    push(V_HLTD, "resume_req");
    step();
    bus.resume = 1'b0;
    push(V_ZERO, "resume_p5");
    step();
    push(V_ZERO, "resume_p6");
    step();
    push(V_ZERO, "resume_p7");
    step();
    bus.resume = 1'b1;
    run_instr(3'd7, 1'b0, V_ZERO, 9'b000010000, 9'b000110000, 0, 7, "jmp_after_resume");
    bus.resume = 1'b0;
`else
    rst = 1'b1;
    push(V_RST, "rst_from_halt");
    step();
    rst = 1'b0;
    run_instr(3'd2, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000, 0, 7, "add_after_halt");
`endif

    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
